text_cursor_writer: RTL and testbench
=====================================

# text_cursor_writer

Upstream producer for the 80×48 character memory (3840 bytes, 12-bit address). Accepts a byte stream from the keyboard/UART decoder over a valid/ready handshake and tracks a text cursor (column, row). Turns each byte into a registered write (data, address, enable) into the character memory. Handles newline, backspace, wrap-around and full-screen clear.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 48, rows per screen
- DATA_W, 8, character code width
- ADDR_W, 12, character memory address width (COLS*ROWS ≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  DATA_W  incoming character/control code
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block can accept a byte this cycle
- wr_en  out  1  one-cycle write strobe to character memory
- wr_addr  out  ADDR_W  write address, row*COLS+col
- wr_data  out  DATA_W  write data
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  6  current row, 0..ROWS-1
- busy  out  1  high while a clear sweep is in progress

## Operation
- States: CLEAR, IDLE.
- The reset value of every output is 0 except busy=1. State=CLEAR and sweep counter=0 during reset.
- CLEAR: each rising edge registers wr_en=1, wr_addr=cnt, wr_data=0x00, then cnt++. rx_ready=0 and busy=1 throughout.
  - The edge that registers cnt=COLS*ROWS-1 also moves state to IDLE, clears the cursor to (0,0) and clears cnt.
- IDLE: rx_ready=1, which is combinational from state. A byte is accepted when rx_valid&&rx_ready.
- Accepted byte dispatch, with results registered on the same edge:
  - 0x20–0x7E: write rx_data at the current cursor, then advance. col=COLS-1 → col=0, row+1.
  - 0x0A or 0x0D: no write. col=0, row+1.
  - 0x08 (backspace): the cursor moves back one position and 0x00 is written at the new position.
    - col=0 → col=COLS-1, row-1.
    - At (0,0): no write, no move.
  - 0x0C (form feed): no write. Enter CLEAR with cnt=0.
  - Any other code: consumed silently, no write, cursor unchanged.
- Row wrap: row advance past ROWS-1 goes to row 0. There is no scrolling; old text is overwritten.
- Address arithmetic: wr_addr=(row<<6)+(row<<4)+col, computed at ADDR_W width. Maximum value is 3839, so there is no overflow.
- wr_en is low in every IDLE cycle without a writing byte.

## Timing
- Write latency: wr_en/wr_addr/wr_data are valid in the cycle after the accept edge, for exactly one cycle.
- The cursor outputs update on the same edge as the write outputs.
  - For printable bytes, wr_addr reflects the pre-advance position.
  - For backspace, wr_addr reflects the post-move position.
- Throughput: one byte per cycle in IDLE. Back-to-back printable bytes give back-to-back write strobes.
- Clear sweep: COLS*ROWS=3840 consecutive wr_en cycles.
  - After reset release, the writes occupy cycles 1..3840.
  - rx_ready rises in cycle 3840, concurrent with the last clear write.
  - The first byte can be accepted at the end of cycle 3840.
- Form feed: the accept edge enters CLEAR, so rx_ready=0 from the next cycle. Writes follow for 3840 cycles.
- The character memory samples wr_en/wr_addr/wr_data on the next rising clk.
- Reset asserted mid-sweep or mid-write: all outputs return to reset values immediately (asynchronous). The sweep restarts from address 0 after release.

## Structure
- Package text_pkg holds:
  - COLS, ROWS, DATA_W, ADDR_W
  - control code constants: CH_BS=0x08, CH_LF=0x0A, CH_FF=0x0C, CH_CR=0x0D, CH_BLANK=0x00
  - state enum {CLEAR, IDLE}
- One sub-module: text_addr_calc, combinational (row, col) → row*COLS+col. Shared with the display read side.
- Cursor update logic and the FSM stay in text_cursor_writer.

## Test plan
- Reset release, rx_valid=0 → wr_en high for exactly 3840 cycles with wr_addr 0..3839 and wr_data=0. rx_ready rises in cycle 3840; cursor is (0,0).
- After clear, send 'A','B' (0x41,0x42) back-to-back → writes (addr 0, 0x41) and (addr 1, 0x42) in consecutive cycles; cursor is (2,0).
- Cursor at (79,3), send 0x58 → write at addr 319; cursor (0,4). Then send 0x08 → write 0x00 at addr 319; cursor (79,3).
- Cursor at (5,47), send 0x0D → no wr_en; cursor (0,0). Then send 0x08 at (0,0) → no wr_en, cursor unchanged. Then send 0x07 → consumed, no wr_en.
- Cursor at (10,10), send 0x0C → rx_ready=0 next cycle; 3840 zero writes; cursor (0,0); then IDLE.
- Assert rst at sweep address 1000 → outputs reset immediately. After release, the sweep restarts at address 0 and runs a full 3840 cycles.

Source files
------------

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and types for the text cursor writer
package text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 48;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BLANK = 8'h00;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/text_addr_calc.sv
// rtl/text_addr_calc.sv - combinational (row, col) to linear character memory address
// Ports:
//   row_i  - cursor row
//   col_i  - cursor column
//   addr_o - row*COLS+col at ADDR_W width
module text_addr_calc #(
    parameter int COLS   = text_pkg::COLS,
    parameter int ADDR_W = text_pkg::ADDR_W
) (
    input  logic [5:0]        row_i,
    input  logic [6:0]        col_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Multiply by a constant; with COLS=80 this reduces to (row<<6)+(row<<4).
    assign addr_o = ADDR_W'(row_i) * ADDR_W'(COLS) + ADDR_W'(col_i);

endmodule

// File: rtl/text_cursor_writer.sv
// rtl/text_cursor_writer.sv - byte stream to character memory writes with cursor tracking
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   rx_data/valid     - incoming character/control byte
//   rx_ready          - high in IDLE, a byte is accepted on rx_valid&&rx_ready
//   wr_en/addr/data   - registered one-cycle write into character memory
//   cursor_col/row    - current cursor position
//   busy              - high while the clear sweep runs
module text_cursor_writer #(
    parameter int COLS   = text_pkg::COLS,
    parameter int ROWS   = text_pkg::ROWS,
    parameter int DATA_W = text_pkg::DATA_W,
    parameter int ADDR_W = text_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic              busy
);
    import text_pkg::*;

    localparam int CELLS = COLS * ROWS;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [6:0]        col_q, col_d;
    logic [5:0]        row_q, row_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [ADDR_W-1:0] here_addr, back_addr;
    logic [6:0]        back_col;
    logic [5:0]        back_row, next_row;
    logic              at_origin, printable;

    // Backspace target: one cell earlier, wrapping to the end of the previous row.
    assign back_col  = (col_q == 7'd0) ? 7'(COLS - 1) : col_q - 7'd1;
    assign back_row  = (col_q == 7'd0) ? row_q - 6'd1 : row_q;
    assign next_row  = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;
    assign at_origin = (col_q == 7'd0) && (row_q == 6'd0);
    assign printable = (rx_data >= DATA_W'(8'h20)) && (rx_data <= DATA_W'(8'h7E));

    text_addr_calc #(.COLS(COLS), .ADDR_W(ADDR_W)) u_here (
        .row_i  (row_q),
        .col_i  (col_q),
        .addr_o (here_addr)
    );

    text_addr_calc #(.COLS(COLS), .ADDR_W(ADDR_W)) u_back (
        .row_i  (back_row),
        .col_i  (back_col),
        .addr_o (back_addr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = DATA_W'(CH_BLANK);
                if (cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    col_d   = 7'd0;
                    row_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (rx_valid) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = here_addr;
                        wr_data_d = rx_data;
                        if (col_q == 7'(COLS - 1)) begin
                            col_d = 7'd0;
                            row_d = next_row;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else if (rx_data == DATA_W'(CH_LF) || rx_data == DATA_W'(CH_CR)) begin
                        col_d = 7'd0;
                        row_d = next_row;
                    end else if (rx_data == DATA_W'(CH_BS)) begin
                        if (!at_origin) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = back_addr;
                            wr_data_d = DATA_W'(CH_BLANK);
                            col_d     = back_col;
                            row_d     = back_row;
                        end
                    end else if (rx_data == DATA_W'(CH_FF)) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            col_q     <= 7'd0;
            row_q     <= 6'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_CLEAR);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
// tb/tb_text_cursor_writer.sv - scoreboard bench for text_cursor_writer
module tb_text_cursor_writer;

    localparam int NCELL = 80 * 48;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int pos = 0;

    text_cursor_writer dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), e >> 8);
                chk("wr_data", int'(wr_data), e & 255);
            end
        end
    end

    // Reference model on a linear cell index pos = row*80+col.
    task automatic model(input logic [7:0] b, output bit wrote, output bit ff);
        wrote = 1'b0;
        ff    = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back((pos << 8) | int'(b));
            pos   = (pos + 1) % NCELL;
            wrote = 1'b1;
        end else if (b == 8'h0A || b == 8'h0D) begin
            pos = ((pos / 80 + 1) % 48) * 80;
        end else if (b == 8'h08) begin
            if (pos > 0) begin
                pos   = pos - 1;
                exp_q.push_back(pos << 8);
                wrote = 1'b1;
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < NCELL; i++) exp_q.push_back(i << 8);
            ff = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
    task automatic send(input logic [7:0] b);
        bit wrote, ff;
        int old_pos;
        int g;
        rx_data  = b;
        rx_valid = 1'b1;
        g = 0;
        while (!rx_ready && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (!rx_ready) chk("ready_timeout", 0, 1);
        old_pos = pos;
        model(b, wrote, ff);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("wr_en_after_accept", int'(wr_en), int'(wrote));
        if (ff) begin
            chk("ff_ready_low", int'(rx_ready), 0);
            chk("ff_busy", int'(busy), 1);
            chk("ff_cursor_col", int'(cursor_col), old_pos % 80);
            chk("ff_cursor_row", int'(cursor_row), old_pos / 80);
        end else begin
            chk("cursor_col", int'(cursor_col), pos % 80);
            chk("cursor_row", int'(cursor_row), pos / 80);
        end
    endtask

    // Sweep starts on the next edge; the 3840th write coincides with rx_ready rising.
    task automatic wait_sweep();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rx_ready && n < 5000);
        chk("sweep_len", n, NCELL);
        chk("last_write_en", int'(wr_en), 1);
        chk("last_write_addr", int'(wr_addr), NCELL - 1);
        chk("sweep_queue_tail", exp_q.size(), 1);
        chk("idle_busy", int'(busy), 0);
        chk("clear_cursor_col", int'(cursor_col), 0);
        chk("clear_cursor_row", int'(cursor_row), 0);
        pos = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_rx_ready", int'(rx_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cursor_col", int'(cursor_col), 0);
        chk("rst_cursor_row", int'(cursor_row), 0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    initial begin
        int g;
        logic [7:0] b;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk); #1;
        check_reset_values();
        for (int i = 0; i < NCELL; i++) exp_q.push_back(i << 8);
        rst = 1'b0;
        wait_sweep();

        // Back-to-back printable bytes.
        send(8'h41);
        chk("A_addr", int'(wr_addr), 0);
        chk("A_data", int'(wr_data), 8'h41);
        send(8'h42);
        chk("B_addr", int'(wr_addr), 1);
        chk("B_data", int'(wr_data), 8'h42);

        // Move to (79,3), write at the end of the row, then backspace over it.
        send(8'h0D);
        send(8'h0A);
        send(8'h0D);
        repeat (79) send(rand_print());
        send(8'h58);
        chk("eol_addr", int'(wr_addr), 319);
        send(8'h08);
        chk("bs_wrap_addr", int'(wr_addr), 319);
        chk("bs_wrap_data", int'(wr_data), 0);

        // Move to (5,47); CR wraps to (0,0); backspace at origin and unknown code are no-ops.
        repeat (44) send(8'h0A);
        repeat (5) send(rand_print());
        chk("pre_cr_row", int'(cursor_row), 47);
        send(8'h0D);
        send(8'h08);
        send(8'h07);

        // Randomised mix with occasional idle cycles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("idle_no_write", int'(wr_en), 0);
            end
            case ($urandom_range(0, 9))
                6:       b = 8'h0A;
                7:       b = 8'h0D;
                8:       b = 8'h08;
                9: begin
                    b = 8'($urandom_range(0, 255));
                    if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
                        b == 8'h0C || b == 8'h0D) b = 8'h07;
                end
                default: b = rand_print();
            endcase
            send(b);
        end

        // Move to (10,10) and form feed.
        g = 0;
        while (pos / 80 != 10 && g < 60) begin
            send(8'h0A);
            g++;
        end
        if (pos % 80 != 0) send(8'h0D);
        while (pos / 80 != 10 && g < 120) begin
            send(8'h0A);
            g++;
        end
        repeat (10) send(rand_print());
        chk("pre_ff_col", int'(cursor_col), 10);
        chk("pre_ff_row", int'(cursor_row), 10);
        send(8'h0C);
        wait_sweep();

        // Reset in the middle of a sweep.
        send(8'h0C);
        g = 0;
        while (!(wr_en && wr_addr == 12'd1000) && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("reached_addr_1000", int'(wr_addr), 1000);
        #1 rst = 1'b1;
        #1 check_reset_values();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NCELL; i++) exp_q.push_back(i << 8);
        rst = 1'b0;
        wait_sweep();

        send(8'h5A);
        chk("post_reset_addr", int'(wr_addr), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
